// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the 3-bit computer front end: opcodes, fetch FSM
// encodings and the PC width derivation.
package instruction_fetch_pkg;

  localparam int PROG_DEPTH_DEFAULT = 16;

  function automatic int pc_width(input int depth);
    return $clog2(depth);
  endfunction

  localparam int PC_W_DEFAULT = pc_width(PROG_DEPTH_DEFAULT);

  // Opcodes of the 3-bit machine, shared with instruction_decode
  localparam logic [2:0] OP_ADV = 3'd0;
  localparam logic [2:0] OP_BXL = 3'd1;
  localparam logic [2:0] OP_BST = 3'd2;
  localparam logic [2:0] OP_JNZ = 3'd3;
  localparam logic [2:0] OP_BXC = 3'd4;
  localparam logic [2:0] OP_OUT = 3'd5;
  localparam logic [2:0] OP_BDV = 3'd6;
  localparam logic [2:0] OP_CDV = 3'd7;

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  typedef struct packed {
    logic [2:0] opcode;
    logic [2:0] operand;
  } instr_pair_t;

endpackage

// File: rtl/instruction_fetch_program_mem.sv
// Program store: one synchronous write port and two combinational read
// ports so an opcode/operand pair is read in a single cycle.
module program_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2:0]      wr_data,
  input  logic [2*AW-1:0] rd_addr,
  output logic [5:0]      rd_data
);

  logic [2:0] mem_reg [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
  end

  // Port 0 serves the operand (pc+1), port 1 the opcode (pc)
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      assign rd_data[gi*3 +: 3] = mem_reg[rd_addr[gi*AW +: AW]];
    end
  endgenerate

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: loads a program of 3-bit words, then issues
// opcode/operand pairs, honouring stall and JNZ redirects, until halt.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int PROG_DEPTH = 16,
  parameter int PC_W       = $clog2(PROG_DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  input  logic [2:0]      load_data,
  input  logic            load_last,
  output logic            load_ready,
  input  logic            restart,
  input  logic            stall,
  input  logic            jump_taken,
  input  logic [PC_W-1:0] jump_target,
  output logic [2:0]      opcode,
  output logic [2:0]      operand,
  output logic            instr_valid,
  output logic [PC_W-1:0] pc,
  output logic            halt
);

  logic [1:0]      state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [PC_W-1:0] wr_ptr_reg;
  logic [PC_W:0]   prog_len_reg;
  instr_pair_t     pair_reg;
  logic            instr_valid_reg;
  logic            halt_reg;

  logic            load_hs;
  logic            load_end;
  logic [PC_W:0]   pc_ext_plus1;
  logic [PC_W:0]   pc_ext_plus2;
  logic [PC_W-1:0] pc_seq_next;
  logic            fetch_ok;
  logic [5:0]      rd_data;
  instr_pair_t     fetched;

  assign load_ready   = (state_reg == ST_LOAD);
  assign load_hs      = load_valid & load_ready;
  assign load_end     = load_last | (wr_ptr_reg == PC_W'(PROG_DEPTH - 1));
  assign pc_ext_plus1 = {1'b0, pc_reg} + (PC_W+1)'(1);
  assign pc_ext_plus2 = {1'b0, pc_reg} + (PC_W+1)'(2);
  assign fetch_ok     = pc_ext_plus1 < prog_len_reg;

  // Stepping past the top of memory pins pc at the last address, which
  // can never start a pair, so the next fetch attempt halts.
  assign pc_seq_next = pc_ext_plus2[PC_W] ? {PC_W{1'b1}} : pc_ext_plus2[PC_W-1:0];

  program_mem #(
    .DEPTH (PROG_DEPTH),
    .AW    (PC_W)
  ) u_program_mem (
    .clk     (clk),
    .wr_en   (load_hs),
    .wr_addr (wr_ptr_reg),
    .wr_data (load_data),
    .rd_addr ({pc_reg, pc_ext_plus1[PC_W-1:0]}),
    .rd_data (rd_data)
  );

  assign fetched = instr_pair_t'(rd_data);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_LOAD;
      pc_reg          <= '0;
      wr_ptr_reg      <= '0;
      prog_len_reg    <= '0;
      pair_reg        <= '0;
      instr_valid_reg <= 1'b0;
      halt_reg        <= 1'b0;
    end else begin
      case (state_reg)
        ST_LOAD: begin
          if (load_hs) begin
            wr_ptr_reg <= wr_ptr_reg + PC_W'(1);
            if (load_end) begin
              prog_len_reg <= {1'b0, wr_ptr_reg} + (PC_W+1)'(1);
              pc_reg       <= '0;
              state_reg    <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (jump_taken) begin
            pc_reg          <= jump_target;
            instr_valid_reg <= 1'b0;
          end else if (!stall) begin
            if (fetch_ok) begin
              pair_reg        <= fetched;
              instr_valid_reg <= 1'b1;
              pc_reg          <= pc_seq_next;
            end else begin
              instr_valid_reg <= 1'b0;
              halt_reg        <= 1'b1;
              state_reg       <= ST_HALTED;
            end
          end
        end
        ST_HALTED: begin
          instr_valid_reg <= 1'b0;
          if (restart) begin
            wr_ptr_reg   <= '0;
            prog_len_reg <= '0;
            pc_reg       <= '0;
            halt_reg     <= 1'b0;
            state_reg    <= ST_LOAD;
          end
        end
        default: begin
          state_reg <= ST_LOAD;
        end
      endcase
    end
  end

  assign opcode      = pair_reg.opcode;
  assign operand     = pair_reg.operand;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign halt        = halt_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized programs,
// checked cycle by cycle against a behavioural model of the fetch rules.
module tb_instruction_fetch;

  localparam int DEPTH = 16;
  localparam int PW    = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_valid;
  logic [2:0]    load_data;
  logic          load_last;
  logic          load_ready;
  logic          restart;
  logic          stall;
  logic          jump_taken;
  logic [PW-1:0] jump_target;
  logic [2:0]    opcode;
  logic [2:0]    operand;
  logic          instr_valid;
  logic [PW-1:0] pc;
  logic          halt;

  always #5 clk = ~clk;

  instruction_fetch #(.PROG_DEPTH(DEPTH), .PC_W(PW)) dut (
    .clk         (clk),
    .rst         (rst),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .restart     (restart),
    .stall       (stall),
    .jump_taken  (jump_taken),
    .jump_target (jump_target),
    .opcode      (opcode),
    .operand     (operand),
    .instr_valid (instr_valid),
    .pc          (pc),
    .halt        (halt)
  );

  // Reference model: mode 0=loading, 1=running, 2=halted
  int m_mode, m_len, m_wr, m_pc, m_op, m_opd, m_iv, m_halt;
  int m_mem [DEPTH];

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] got_q [$];
  logic [5:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_wr = 0; m_pc = 0;
    m_op = 0; m_opd = 0; m_iv = 0; m_halt = 0;
  endtask

  task automatic model_step();
    if (m_mode == 0) begin
      if (load_valid) begin
        m_mem[m_wr] = int'(load_data);
        if (load_last || m_wr == DEPTH - 1) begin
          m_len  = m_wr + 1;
          m_pc   = 0;
          m_mode = 1;
        end
        m_wr = (m_wr + 1) % DEPTH;
      end
    end else if (m_mode == 1) begin
      if (jump_taken) begin
        m_pc = int'(jump_target);
        m_iv = 0;
      end else if (!stall) begin
        if (m_pc + 1 < m_len) begin
          m_op  = m_mem[m_pc];
          m_opd = m_mem[m_pc + 1];
          m_iv  = 1;
          m_pc  = (m_pc + 2 > DEPTH - 1) ? DEPTH - 1 : m_pc + 2;
        end else begin
          m_iv = 0; m_halt = 1; m_mode = 2;
        end
      end
    end else begin
      m_iv = 0;
      if (restart) begin
        m_wr = 0; m_len = 0; m_pc = 0; m_halt = 0; m_mode = 0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".load_ready"}, load_ready, (m_mode == 0) ? 1 : 0);
    chk({tag, ".instr_valid"}, instr_valid, m_iv);
    chk({tag, ".halt"}, halt, m_halt);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".opcode"}, opcode, m_op);
    chk({tag, ".operand"}, operand, m_opd);
  endtask

  task automatic idle();
    load_valid = 0; load_data = 0; load_last = 0;
    restart = 0; stall = 0; jump_taken = 0; jump_target = 0;
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    if (instr_valid === 1'b1 && !stall) begin
      got_q.push_back({opcode, operand});
      $display("issue op=%0d opd=%0d pc=%0d", opcode, operand, pc);
    end
    check_all("cycle");
  endtask

  task automatic load_word(input int d, input bit last);
    load_valid = 1; load_data = 3'(d); load_last = last;
    step();
    load_valid = 0; load_last = 0;
  endtask

  task automatic do_restart();
    restart = 1;
    step();
    restart = 0;
  endtask

  task automatic push_exp(input int op, input int opd);
    exp_q.push_back({3'(op), 3'(opd)});
  endtask

  task automatic run_to_halt(input int budget, input bit rnd);
    int k = 0;
    int jumps = 3;
    while (halt !== 1'b1 && k < budget) begin
      if (rnd) begin
        stall      = ($urandom_range(0, 3) == 0);
        load_valid = ($urandom_range(0, 4) == 0);
        restart    = ($urandom_range(0, 6) == 0);
        if (jumps > 0 && $urandom_range(0, 9) == 0) begin
          jump_taken  = 1;
          jump_target = PW'($urandom_range(0, DEPTH - 1));
          jumps--;
        end
      end
      step();
      idle();
      k++;
    end
    chk("halt_reached", halt, 1);
  endtask

  task automatic check_issued(input string tag);
    chk({tag, ".count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk({tag, ".pair"}, got_q[i], exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    idle();
    rst = 1;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst = 0;

    // 1: basic load and two pairs
    load_word(2, 0); load_word(4, 0); load_word(1, 0); load_word(1, 1);
    chk("t1.ready_drop", load_ready, 0);
    run_to_halt(20, 0);
    chk("t1.pc_final", pc, 4);
    push_exp(2, 4); push_exp(1, 1);
    check_issued("t1");

    // 2: jump back to 0 while the third pair is presented
    do_restart();
    load_word(0, 0); load_word(3, 0); load_word(5, 0);
    load_word(4, 0); load_word(3, 0); load_word(0, 1);
    step(); step(); step();
    chk("t2.third_op", opcode, 3);
    jump_taken = 1; jump_target = 0;
    step();
    idle();
    chk("t2.bubble", instr_valid, 0);
    run_to_halt(30, 0);
    push_exp(0, 3); push_exp(5, 4); push_exp(3, 0);
    push_exp(0, 3); push_exp(5, 4); push_exp(3, 0);
    check_issued("t2");

    // 3: three-cycle stall after the first pair
    do_restart();
    for (int i = 1; i <= 6; i++) load_word(i, i == 6);
    step();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3.pc_frozen", pc, 2);
    end
    stall = 0;
    run_to_halt(20, 0);
    push_exp(1, 2); push_exp(3, 4); push_exp(5, 6);
    check_issued("t3");

    // 4: odd length, then odd jump target on a two-word program
    do_restart();
    load_word(1, 0); load_word(7, 0); load_word(5, 1);
    run_to_halt(20, 0);
    chk("t4.pc_final", pc, 2);
    push_exp(1, 7);
    check_issued("t4a");
    do_restart();
    load_word(3, 0); load_word(2, 1);
    jump_taken = 1; jump_target = 1;
    step();
    idle();
    run_to_halt(20, 0);
    check_issued("t4b");

    // 5: memory full without load_last
    do_restart();
    for (int i = 0; i < DEPTH; i++) load_word(i % 8, 0);
    chk("t5.implicit_last", load_ready, 0);
    run_to_halt(40, 0);
    chk("t5.pc_sat", pc, DEPTH - 1);
    for (int r = 0; r < 2; r++) begin
      push_exp(0, 1); push_exp(2, 3); push_exp(4, 5); push_exp(6, 7);
    end
    check_issued("t5");

    // 6: asynchronous reset mid-run, then a fresh program
    do_restart();
    for (int i = 1; i <= 6; i++) load_word(i, i == 6);
    step(); step();
    #2;
    rst = 1;
    #1;
    model_reset();
    check_all("async_rst");
    got_q.delete();
    @(negedge clk);
    rst = 0;
    load_word(7, 0); load_word(6, 0); load_word(5, 0); load_word(4, 1);
    run_to_halt(20, 0);
    push_exp(7, 6); push_exp(5, 4);
    check_issued("t6a");
    do_restart();
    load_word(2, 0); load_word(1, 1);
    run_to_halt(20, 0);
    push_exp(2, 1);
    check_issued("t6b");

    // Randomized programs with stalls, jumps and ignored inputs
    for (int t = 0; t < 25; t++) begin
      int n;
      do_restart();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) step();
        load_word($urandom_range(0, 7), (i == n - 1) && (n < DEPTH || $urandom_range(0, 1) == 1));
      end
      run_to_halt(200, 1);
      got_q.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
